// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer for an 8259-style PIC in 8086 two-pulse mode.
// Raises INT, answers the INTA pair and sets/clears ISR bits. Supports cascade master and slave roles.
module inta_sequencer #(
  parameter int IR_W = 8,
  parameter int ID_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              INTFLAG,
  input  logic [ID_W-1:0]   PriorityID,
  input  logic              INTA,
  input  logic [4:0]        vector_base,
  input  logic              single_mode,
  input  logic              auto_eoi,
  input  logic              slave_program,
  input  logic [IR_W-1:0]   slave_config,
  input  logic [ID_W-1:0]   slave_id,
  input  logic [ID_W-1:0]   cascade_in,
  output logic [ID_W-1:0]   cascade_out,
  output logic              cascade_oe,
  output logic              INT,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output logic [IR_W-1:0]   isr_set,
  output logic [IR_W-1:0]   isr_auto_clear,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, PEND, ACK1, WAIT2, ACK2} state_t;

  state_t            state_reg;
  logic              inta_q;
  logic [ID_W-1:0]   sel_id_reg;
  logic              spurious_reg;

  logic              fall;
  logic              rise;
  logic [ID_W-1:0]   ack_id;
  logic              cascade_hit;
  logic              responsible;

  assign fall   = inta_q & ~INTA;
  assign rise   = ~inta_q & INTA;
  // A request that vanished before the first pulse is answered as IR7.
  assign ack_id = INTFLAG ? PriorityID : {ID_W{1'b1}};

  assign cascade_hit = slave_program & ~single_mode & slave_config[ack_id];
  assign responsible = single_mode
                     | (slave_program & ~slave_config[sel_id_reg])
                     | (~slave_program & (cascade_in == slave_id));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      inta_q         <= 1'b1;
      sel_id_reg     <= '0;
      spurious_reg   <= 1'b0;
      cascade_out    <= '0;
      cascade_oe     <= 1'b0;
      INT            <= 1'b0;
      data_out       <= '0;
      data_oe        <= 1'b0;
      isr_set        <= '0;
      isr_auto_clear <= '0;
      busy           <= 1'b0;
    end else begin
      inta_q         <= INTA;
      isr_set        <= '0;
      isr_auto_clear <= '0;
      case (state_reg)
        IDLE: begin
          if (INTFLAG) begin
            state_reg <= PEND;
            INT       <= 1'b1;
            busy      <= 1'b1;
          end
        end
        PEND: begin
          if (fall) begin
            state_reg    <= ACK1;
            INT          <= 1'b0;
            sel_id_reg   <= ack_id;
            spurious_reg <= ~INTFLAG;
            if (INTFLAG)
              isr_set <= {{(IR_W-1){1'b0}}, 1'b1} << PriorityID;
            cascade_oe  <= cascade_hit;
            cascade_out <= cascade_hit ? ack_id : '0;
          end
        end
        ACK1: begin
          if (rise)
            state_reg <= WAIT2;
        end
        WAIT2: begin
          if (fall) begin
            state_reg <= ACK2;
            data_oe   <= responsible;
            data_out  <= responsible ? {vector_base, sel_id_reg} : 8'h00;
          end
        end
        ACK2: begin
          if (rise) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            data_oe     <= 1'b0;
            data_out    <= '0;
            cascade_oe  <= 1'b0;
            cascade_out <= '0;
            if (auto_eoi && !spurious_reg)
              isr_auto_clear <= {{(IR_W-1){1'b0}}, 1'b1} << sel_id_reg;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: single, master, slave, spurious and mid-sequence reset cases.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       INTFLAG;
  logic [2:0] PriorityID;
  logic       INTA;
  logic [4:0] vector_base;
  logic       single_mode;
  logic       auto_eoi;
  logic       slave_program;
  logic [7:0] slave_config;
  logic [2:0] slave_id;
  logic [2:0] cascade_in;
  logic [2:0] cascade_out;
  logic       cascade_oe;
  logic       INT;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] isr_set;
  logic [7:0] isr_auto_clear;
  logic       busy;

  int total = 0;
  int bad   = 0;

  inta_sequencer #(.IR_W(8), .ID_W(3)) dut (
    .clk(clk), .reset(reset), .INTFLAG(INTFLAG), .PriorityID(PriorityID), .INTA(INTA),
    .vector_base(vector_base), .single_mode(single_mode), .auto_eoi(auto_eoi),
    .slave_program(slave_program), .slave_config(slave_config), .slave_id(slave_id),
    .cascade_in(cascade_in), .cascade_out(cascade_out), .cascade_oe(cascade_oe),
    .INT(INT), .data_out(data_out), .data_oe(data_oe), .isr_set(isr_set),
    .isr_auto_clear(isr_auto_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full two-pulse acknowledge; expectations are passed in by the caller.
  task automatic do_seq(input string tag, input logic [2:0] id, input logic drop_flag,
                        input logic [7:0] e_isr, input logic e_doe, input logic [7:0] e_dout,
                        input logic e_coe, input logic [2:0] e_cout, input logic [7:0] e_clr);
    PriorityID = id;
    INTFLAG    = 1'b1;
    check({tag, ".int_pre"}, INT, 0);
    tick();
    check({tag, ".int"}, INT, 1);
    check({tag, ".busy"}, busy, 1);
    if (drop_flag) begin
      INTFLAG = 1'b0;
      tick();
      check({tag, ".int_held"}, INT, 1);
    end
    INTA = 1'b0;
    tick();
    check({tag, ".isr_set"}, isr_set, e_isr);
    check({tag, ".int_ack1"}, INT, 0);
    check({tag, ".coe_ack1"}, cascade_oe, e_coe);
    if (e_coe) check({tag, ".cout"}, cascade_out, e_cout);
    check({tag, ".doe_ack1"}, data_oe, 0);
    INTFLAG = 1'b0;
    tick();
    check({tag, ".isr_once"}, isr_set, 0);
    INTA = 1'b1;
    tick();
    check({tag, ".coe_wait2"}, cascade_oe, e_coe);
    check({tag, ".doe_wait2"}, data_oe, 0);
    INTA = 1'b0;
    tick();
    check({tag, ".doe_ack2"}, data_oe, e_doe);
    if (e_doe) check({tag, ".dout"}, data_out, e_dout);
    check({tag, ".coe_ack2"}, cascade_oe, e_coe);
    tick();
    check({tag, ".clr_early"}, isr_auto_clear, 0);
    INTA = 1'b1;
    tick();
    check({tag, ".doe_exit"}, data_oe, 0);
    check({tag, ".coe_exit"}, cascade_oe, 0);
    check({tag, ".clr"}, isr_auto_clear, e_clr);
    check({tag, ".busy_exit"}, busy, 0);
    tick();
    check({tag, ".clr_once"}, isr_auto_clear, 0);
  endtask

  task automatic set_mode(input logic sngl, input logic aeoi, input logic sp,
                          input logic [7:0] cfg, input logic [2:0] sid, input logic [2:0] cin);
    single_mode   = sngl;
    auto_eoi      = aeoi;
    slave_program = sp;
    slave_config  = cfg;
    slave_id      = sid;
    cascade_in    = cin;
  endtask

  initial begin
    reset = 1'b1; INTFLAG = 1'b0; PriorityID = 3'd0; INTA = 1'b1;
    vector_base = 5'b01000;
    set_mode(1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0);
    tick(); tick();
    reset = 1'b0;
    check("rst.int", INT, 0);
    check("rst.busy", busy, 0);
    check("rst.data_oe", data_oe, 0);
    check("rst.cascade_oe", cascade_oe, 0);
    check("rst.isr_set", isr_set, 0);
    check("rst.data_out", data_out, 0);
    tick();

    do_seq("single", 3'd3, 1'b0, 8'h08, 1'b1, 8'h43, 1'b0, 3'd0, 8'h00);
    set_mode(1'b1, 1'b1, 1'b1, 8'h00, 3'd0, 3'd0);
    do_seq("single_aeoi", 3'd3, 1'b0, 8'h08, 1'b1, 8'h43, 1'b0, 3'd0, 8'h08);
    set_mode(1'b0, 1'b0, 1'b1, 8'h04, 3'd0, 3'd0);
    do_seq("master_cas", 3'd2, 1'b0, 8'h04, 1'b0, 8'h00, 1'b1, 3'd2, 8'h00);
    do_seq("master_own", 3'd1, 1'b0, 8'h02, 1'b1, 8'h41, 1'b0, 3'd0, 8'h00);
    set_mode(1'b0, 1'b0, 1'b0, 8'h00, 3'd2, 3'd2);
    do_seq("slave_hit", 3'd5, 1'b0, 8'h20, 1'b1, 8'h45, 1'b0, 3'd0, 8'h00);
    set_mode(1'b0, 1'b0, 1'b0, 8'h00, 3'd2, 3'd5);
    do_seq("slave_miss", 3'd5, 1'b0, 8'h20, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    set_mode(1'b1, 1'b1, 1'b1, 8'h00, 3'd0, 3'd0);
    do_seq("spurious", 3'd3, 1'b1, 8'h00, 1'b1, 8'h47, 1'b0, 3'd0, 8'h00);

    // Reset while in ACK1 with the cascade bus driven.
    set_mode(1'b0, 1'b0, 1'b1, 8'h04, 3'd0, 3'd0);
    PriorityID = 3'd2; INTFLAG = 1'b1;
    tick();
    INTA = 1'b0;
    tick();
    check("rst_ack1.pre_coe", cascade_oe, 1);
    reset = 1'b1; INTA = 1'b1; INTFLAG = 1'b0;
    tick();
    check("rst_ack1.int", INT, 0);
    check("rst_ack1.coe", cascade_oe, 0);
    check("rst_ack1.doe", data_oe, 0);
    check("rst_ack1.busy", busy, 0);
    reset = 1'b0;
    tick();
    check("rst_ack1.idle", busy, 0);

    // Reset while in ACK2 with the data bus driven.
    set_mode(1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0);
    PriorityID = 3'd3; INTFLAG = 1'b1;
    tick();
    INTA = 1'b0;
    tick();
    INTFLAG = 1'b0; INTA = 1'b1;
    tick();
    INTA = 1'b0;
    tick();
    check("rst_ack2.pre_doe", data_oe, 1);
    reset = 1'b1; INTA = 1'b1;
    tick();
    check("rst_ack2.int", INT, 0);
    check("rst_ack2.coe", cascade_oe, 0);
    check("rst_ack2.doe", data_oe, 0);
    check("rst_ack2.busy", busy, 0);
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
